ram_refresh_sched: RTL

- Refresh scheduler for the DRAM controller in the SE accelerator CPLD; runs on the FSB clock.
- Produces RefReq and RefUrgent for the RAM sequencer and consumes its RefAck.
- Tracks a saturating debt of owed CAS-before-RAS refreshes. The FSB arbiter can therefore defer refresh behind CPU cycles until the debt becomes urgent.
- Runs the mandatory post-reset DRAM init burst before normal operation.

---
 rtl/ram_refresh_pkg.sv | 22 ++
 rtl/ref_interval_ctr.sv | 42 ++++
 rtl/ram_refresh_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ram_refresh_pkg.sv
// Shared constants, state encoding and output bundle for the DRAM refresh scheduler.
// Also referenced by the RAM sequencer and FSB arbiter for matching timing.
package ram_refresh_pkg;

  localparam int unsigned REF_PERIOD_DEF    = 234;
  localparam int unsigned MAX_DEBT_DEF      = 4;
  localparam int unsigned URGENT_THRESH_DEF = 2;
  localparam int unsigned INIT_REFS_DEF     = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_NORM = 1'b1
  } ref_state_e;

  // Registered request bundle presented to the RAM sequencer and FSB arbiter
  typedef struct packed {
    logic req;
    logic urgent;
    logic init;
  } ref_out_t;

endpackage

// File: rtl/ref_interval_ctr.sv
// Reloadable refresh-interval down-counter; tick_c_o is high for the one cycle
// the count sits at zero, giving a tick every PERIOD clocks while not held.
module ref_interval_ctr
  import ram_refresh_pkg::*;
#(
  parameter int unsigned PERIOD = REF_PERIOD_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic hold_i,
  output logic tick_c_o
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Hold pins the count at reload so the first tick lands a full period after release
  always_comb begin
    cnt_d    = cnt_q;
    tick_c_o = 1'b0;
    if (hold_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q == '0) begin
      cnt_d    = RELOAD;
      tick_c_o = 1'b1;
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_refresh_sched.sv
// DRAM refresh scheduler: init burst, then saturating refresh-debt tracking.
// Define REFRESH_STATS_EN to add the RefUrgCnt / RefMaxDebt statistics outputs.
module ram_refresh_sched
  import ram_refresh_pkg::*;
#(
  parameter int unsigned REF_PERIOD    = REF_PERIOD_DEF,
  parameter int unsigned MAX_DEBT      = MAX_DEBT_DEF,
  parameter int unsigned URGENT_THRESH = URGENT_THRESH_DEF,
  parameter int unsigned INIT_REFS     = INIT_REFS_DEF
) (
  input  logic CLK_FSB,
  input  logic nRES,
  input  logic RefAck,
  output logic RefReq,
  output logic RefUrgent,
  output logic RefInit,
  output logic RefOvf
`ifdef REFRESH_STATS_EN
  ,
  output logic [7:0]                       RefUrgCnt,
  output logic [$clog2(MAX_DEBT+1)-1:0]    RefMaxDebt
`endif
);

  localparam int unsigned DW = $clog2(MAX_DEBT + 1);
  localparam int unsigned IW = $clog2(INIT_REFS + 1);
  localparam logic [DW-1:0] DEBT_MAX = DW'(MAX_DEBT);
  localparam logic [DW-1:0] DEBT_URG = DW'(URGENT_THRESH);
  localparam logic [IW-1:0] INIT_CNT = IW'(INIT_REFS);

  ref_state_e    state_q, state_d;
  logic [DW-1:0] debt_q, debt_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic          ovf_q, ovf_d;
  logic          ack_q;
  ref_out_t      out_q, out_d;

  logic          ackp_c;
  logic          tick_c;
  logic          hold_c;

  assign ackp_c = RefAck & ~ack_q;
  assign hold_c = (state_q == ST_INIT);

  ref_interval_ctr #(
    .PERIOD (REF_PERIOD)
  ) u_interval_ctr (
    .clk_i    (CLK_FSB),
    .rst_n_i  (nRES),
    .hold_i   (hold_c),
    .tick_c_o (tick_c)
  );

  // Next state, debt update and decode of the registered outputs from next-state values
  always_comb begin
    state_d    = state_q;
    debt_d     = debt_q;
    init_cnt_d = init_cnt_q;
    ovf_d      = ovf_q;
    out_d      = '0;

    case (state_q)
      ST_INIT: begin
        if (ackp_c) begin
          init_cnt_d = init_cnt_q - IW'(1);
          if (init_cnt_q <= IW'(1)) begin
            init_cnt_d = '0;
            state_d    = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        // A tick and an ack in the same cycle cancel out
        if (tick_c && !ackp_c) begin
          if (debt_q == DEBT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            debt_d = debt_q + DW'(1);
          end
        end else if (ackp_c && !tick_c && (debt_q != '0)) begin
          debt_d = debt_q - DW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    out_d.init   = (state_d == ST_INIT);
    out_d.req    = out_d.init | (debt_d != '0);
    out_d.urgent = out_d.init | (debt_d >= DEBT_URG);
  end

  always_ff @(posedge CLK_FSB) begin
    if (!nRES) begin
      state_q    <= ST_INIT;
      debt_q     <= '0;
      init_cnt_q <= INIT_CNT;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      debt_q     <= debt_d;
      init_cnt_q <= init_cnt_d;
      ovf_q      <= ovf_d;
      ack_q      <= RefAck;
      out_q      <= out_d;
    end
  end

  assign RefReq    = out_q.req;
  assign RefUrgent = out_q.urgent;
  assign RefInit   = out_q.init;
  assign RefOvf    = ovf_q;

`ifdef REFRESH_STATS_EN
  logic [7:0]    urg_cnt_q, urg_cnt_d;
  logic [DW-1:0] max_debt_q, max_debt_d;

  // Count urgent assertions seen during normal operation; track debt high-water mark
  always_comb begin
    urg_cnt_d  = urg_cnt_q;
    max_debt_d = max_debt_q;
    if ((state_q == ST_NORM) && out_d.urgent && !out_q.urgent && (urg_cnt_q != 8'hFF)) begin
      urg_cnt_d = urg_cnt_q + 8'd1;
    end
    if (debt_d > max_debt_q) begin
      max_debt_d = debt_d;
    end
  end

  always_ff @(posedge CLK_FSB) begin
    if (!nRES) begin
      urg_cnt_q  <= '0;
      max_debt_q <= '0;
    end else begin
      urg_cnt_q  <= urg_cnt_d;
      max_debt_q <= max_debt_d;
    end
  end

  assign RefUrgCnt  = urg_cnt_q;
  assign RefMaxDebt = max_debt_q;
`endif

endmodule
